// File: rtl/pu_sequencer.sv
// -----------------------------------------------------------------------------
// pu_sequencer
//
// Upstream controller for the 8-lane processing unit (PU). It buffers one
// layer's input vector (N_CHUNKS chunks of 8 sign-magnitude bytes), then for
// each neuron streams every chunk to the PU together with that neuron's
// weight chunk and bias, captures the PU's activated output after the last
// chunk, and offers it downstream on a valid/ready stream.
//
// Pipeline per neuron:
//   issue   stage : w_addr/b_addr driven from the chunk/neuron counters
//   present stage : one cycle later the synchronous ROM data is valid and is
//                   handed to the PU alongside the buffered input chunk
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input chunk handshake (accepted only while loading)
//   in_data   [63:0]    input chunk, byte k feeds lane k
//   w_addr    [AW-1:0]  weight ROM address (n*N_CHUNKS + c)
//   w_data    [63:0]    weight chunk, valid one cycle after w_addr
//   b_addr    [NW-1:0]  bias ROM address (neuron index)
//   b_data    [7:0]     bias, valid one cycle after b_addr
//   pu_x/pu_w [63:0]    operands presented to the PU
//   pu_bias   [7:0]     bias presented to the PU
//   pu_isfirst          restarts the PU accumulator from the bias
//   pu_out    [7:0]     PU activated output (combinational)
//   out_valid/out_ready result handshake
//   out_data  [7:0]     captured neuron result
//   out_idx   [NW-1:0]  neuron index of out_data
//   layer_done          one-cycle pulse after the last result is accepted
// -----------------------------------------------------------------------------
module pu_sequencer #(
    parameter int N_CHUNKS  = 4,
    parameter int N_NEURONS = 8,
    parameter int CW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1,
    parameter int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    parameter int AW = (N_NEURONS * N_CHUNKS > 1) ? $clog2(N_NEURONS * N_CHUNKS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    output logic [AW-1:0] w_addr,
    input  logic [63:0]   w_data,
    output logic [NW-1:0] b_addr,
    input  logic [7:0]    b_data,
    output logic [63:0]   pu_x,
    output logic [63:0]   pu_w,
    output logic [7:0]    pu_bias,
    output logic          pu_isfirst,
    input  logic [7:0]    pu_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [NW-1:0] out_idx,
    output logic          layer_done
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_LAST = CW'(N_CHUNKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_NEURONS - 1);

    // The buffer covers the whole index range of the chunk counters, so every
    // index is in bounds even when N_CHUNKS is not a power of two.
    localparam int XDEPTH = 1 << CW;

    state_t        r_state;
    state_t        w_state_next;

    logic [63:0]   r_xbuf [XDEPTH];
    logic [CW-1:0] r_ld_cnt;
    logic [CW-1:0] r_c;
    logic [NW-1:0] r_n;
    logic          r_issue_done;

    // Present-stage pipeline registers (describe the chunk issued last cycle).
    logic          r_p_valid;
    logic [CW-1:0] r_p_chunk;
    logic          r_p_first;
    logic          r_p_last;

    logic          r_out_valid;
    logic [7:0]    r_out_data;
    logic [NW-1:0] r_out_idx;
    logic          r_layer_done;

    logic          w_load_beat;
    logic          w_last_load;
    logic          w_issue;
    logic          w_capture;
    logic          w_accept;
    logic          w_last_neuron;

    assign w_load_beat   = (r_state == S_LOAD) && in_valid;
    assign w_last_load   = w_load_beat && (r_ld_cnt == C_LAST);
    assign w_issue       = (r_state == S_COMPUTE) && !r_issue_done;
    assign w_capture     = (r_state == S_COMPUTE) && r_p_valid && r_p_last;
    assign w_accept      = (r_state == S_EMIT) && r_out_valid && out_ready;
    assign w_last_neuron = (r_n == N_LAST);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can infer a latch.
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (w_last_load) begin
                    w_state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (w_capture) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_accept) begin
                    w_state_next = w_last_neuron ? S_LOAD : S_COMPUTE;
                end
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Input vector buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer is deliberately left out of reset: it is always fully
    // rewritten in LOAD before any entry is read, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (w_load_beat) begin
            r_xbuf[r_ld_cnt] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Counters and issue-stage control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt     <= '0;
            r_c          <= '0;
            r_n          <= '0;
            r_issue_done <= 1'b0;
        end else begin
            if (w_last_load) begin
                r_ld_cnt <= '0;
            end else if (w_load_beat) begin
                r_ld_cnt <= r_ld_cnt + 1'b1;
            end

            if (w_last_load) begin
                r_n          <= '0;
                r_c          <= '0;
                r_issue_done <= 1'b0;
            end else if (w_issue) begin
                // The chunk counter parks on the last chunk instead of
                // wrapping, so w_addr stays put while the result waits.
                if (r_c == C_LAST) begin
                    r_issue_done <= 1'b1;
                end else begin
                    r_c <= r_c + 1'b1;
                end
            end else if (w_accept) begin
                r_c          <= '0;
                r_issue_done <= 1'b0;
                r_n          <= w_last_neuron ? '0 : r_n + 1'b1;
                if (w_last_neuron) begin
                    r_ld_cnt <= '0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Present-stage pipeline: follows the issue stage by one cycle so the ROM
    // data and the buffered chunk line up.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_valid <= 1'b0;
            r_p_chunk <= '0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
        end else begin
            r_p_valid <= w_issue;
            if (w_issue) begin
                r_p_chunk <= r_c;
                r_p_first <= (r_c == '0);
                r_p_last  <= (r_c == C_LAST);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result capture and output stream
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_idx    <= '0;
            r_layer_done <= 1'b0;
        end else begin
            r_layer_done <= w_accept && w_last_neuron;
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= pu_out;
                r_out_idx   <= r_n;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign w_addr = AW'(32'(r_n) * N_CHUNKS + 32'(r_c));
    assign b_addr = r_n;

    // Idle cycles present all-zero operands so a stray accumulate is harmless;
    // every neuron still restarts from its bias through pu_isfirst.
    assign pu_x       = r_p_valid ? r_xbuf[r_p_chunk] : '0;
    assign pu_w       = r_p_valid ? w_data : '0;
    assign pu_bias    = r_p_valid ? b_data : '0;
    assign pu_isfirst = r_p_valid & r_p_first;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign layer_done = r_layer_done;

endmodule

// File: tb/tb_pu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pu_sequencer
//
// Two sequencers share clock and reset:
//   dut_a : N_CHUNKS=4, N_NEURONS=3  (addressing, back-pressure, reset, random)
//   dut_b : N_CHUNKS=1, N_NEURONS=1  (table of single-chunk arithmetic cases)
// Each has its own synchronous weight/bias ROMs and a behavioural PU
// (Q0.7 sign-magnitude MAC, accumulator restarted from the bias on isfirst,
// ReLU with saturation to 0x7F). Expected results come from whole-vector dot
// products over the bench's own copies of the input vector and ROMs.
// Inputs are driven at the falling edge, outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_pu_sequencer;

    localparam int A_NC = 4;
    localparam int A_NN = 3;
    localparam int B_NC = 1;
    localparam int B_NN = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- arithmetic helpers (PU definition) ----------------
    function automatic int sm(input logic [7:0] b);
        int m;
        m = int'(b[6:0]);
        return b[7] ? -m : m;
    endfunction

    function automatic int dot(input logic [63:0] x, input logic [63:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) s += sm(x[8*k +: 8]) * sm(w[8*k +: 8]);
        return s;
    endfunction

    function automatic logic [7:0] act(input int s);
        if (s <= 0) return 8'h00;
        if (s / 128 > 127) return 8'h7f;
        return 8'(s / 128);
    endfunction

    function automatic logic [7:0] rand_sm(input int maxmag);
        logic [6:0] m;
        logic       s;
        m = 7'($urandom_range(0, maxmag));
        s = 1'($urandom_range(0, 1));
        return {s, m};
    endfunction

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    // ---------------- instance A ----------------
    logic        a_in_valid, a_in_ready, a_pu_isfirst, a_out_valid, a_out_ready, a_layer_done;
    logic [63:0] a_in_data, a_w_data, a_pu_x, a_pu_w;
    logic [3:0]  a_w_addr;
    logic [1:0]  a_b_addr, a_out_idx;
    logic [7:0]  a_b_data, a_pu_bias, a_pu_out, a_out_data;

    pu_sequencer #(.N_CHUNKS(A_NC), .N_NEURONS(A_NN)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .w_addr(a_w_addr), .w_data(a_w_data), .b_addr(a_b_addr), .b_data(a_b_data),
        .pu_x(a_pu_x), .pu_w(a_pu_w), .pu_bias(a_pu_bias), .pu_isfirst(a_pu_isfirst),
        .pu_out(a_pu_out),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .layer_done(a_layer_done)
    );

    logic [63:0] a_x [A_NC];
    logic [63:0] a_wrom [16];
    logic [7:0]  a_brom [4];

    always @(posedge clk) begin
        a_w_data <= a_wrom[a_w_addr];
        a_b_data <= a_brom[a_b_addr];
    end

    int a_acc = 0;
    int a_sum;
    always_comb a_sum = (a_pu_isfirst ? sm(a_pu_bias) * 128 : a_acc) + dot(a_pu_x, a_pu_w);
    assign a_pu_out = act(a_sum);
    always @(posedge clk) a_acc <= a_sum;

    function automatic logic [7:0] ref_a(input int n);
        int s;
        s = sm(a_brom[n]) * 128;
        for (int c = 0; c < A_NC; c++) s += dot(a_x[c], a_wrom[n*A_NC + c]);
        return act(s);
    endfunction

    // ---------------- instance B ----------------
    logic        b_in_valid, b_in_ready, b_pu_isfirst, b_out_valid, b_out_ready, b_layer_done;
    logic [63:0] b_in_data, b_w_data, b_pu_x, b_pu_w;
    logic [0:0]  b_w_addr, b_b_addr, b_out_idx;
    logic [7:0]  b_b_data, b_pu_bias, b_pu_out, b_out_data;

    pu_sequencer #(.N_CHUNKS(B_NC), .N_NEURONS(B_NN)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .w_addr(b_w_addr), .w_data(b_w_data), .b_addr(b_b_addr), .b_data(b_b_data),
        .pu_x(b_pu_x), .pu_w(b_pu_w), .pu_bias(b_pu_bias), .pu_isfirst(b_pu_isfirst),
        .pu_out(b_pu_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .layer_done(b_layer_done)
    );

    logic [63:0] b_wrom [2];
    logic [7:0]  b_brom [2];

    always @(posedge clk) begin
        b_w_data <= b_wrom[b_w_addr];
        b_b_data <= b_brom[b_b_addr];
    end

    int b_acc = 0;
    int b_sum;
    always_comb b_sum = (b_pu_isfirst ? sm(b_pu_bias) * 128 : b_acc) + dot(b_pu_x, b_pu_w);
    assign b_pu_out = act(b_sum);
    always @(posedge clk) b_acc <= b_sum;

    // ---------------- single-chunk vector table ----------------
    typedef struct packed {
        logic [7:0] x_b;
        logic [7:0] w_b;
        logic [7:0] bias;
        logic [7:0] exp_out;
    } vec_t;

    vec_t b_vecs [8];

    task automatic run_vec_b(input int idx, input vec_t v);
        logic [63:0] x, w;
        x = {56'h0, v.x_b};
        w = {56'h0, v.w_b};
        b_wrom[0] = w;
        b_brom[0] = v.bias;
        b_in_valid = 1'b1;
        b_in_data  = x;
        @(negedge clk);                       // issue cycle
        b_in_valid = 1'b0;
        b_in_data  = '0;
        check($sformatf("b%0d_waddr", idx), 64'(b_w_addr), 64'd0);
        check($sformatf("b%0d_idle_first", idx), 64'(b_pu_isfirst), 64'd0);
        check($sformatf("b%0d_early_valid", idx), 64'(b_out_valid), 64'd0);
        @(negedge clk);                       // present cycle
        check($sformatf("b%0d_isfirst", idx), 64'(b_pu_isfirst), 64'd1);
        check($sformatf("b%0d_pu_x", idx), b_pu_x, x);
        check($sformatf("b%0d_pu_w", idx), b_pu_w, w);
        check($sformatf("b%0d_pu_bias", idx), 64'(b_pu_bias), 64'(v.bias));
        @(negedge clk);                       // result cycle
        check($sformatf("b%0d_valid", idx), 64'(b_out_valid), 64'd1);
        check($sformatf("b%0d_data", idx), 64'(b_out_data), 64'(v.exp_out));
        check($sformatf("b%0d_idx", idx), 64'(b_out_idx), 64'd0);
        check($sformatf("b%0d_in_ready_emit", idx), 64'(b_in_ready), 64'd0);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check($sformatf("b%0d_done", idx), 64'(b_layer_done), 64'd1);
        check($sformatf("b%0d_valid_drop", idx), 64'(b_out_valid), 64'd0);
        check($sformatf("b%0d_in_ready", idx), 64'(b_in_ready), 64'd1);
        @(negedge clk);
        check($sformatf("b%0d_done_pulse", idx), 64'(b_layer_done), 64'd0);
    endtask

    // ---------------- instance A sequences ----------------
    task automatic randomize_a(input int maxmag);
        for (int c = 0; c < A_NC; c++)
            for (int k = 0; k < 8; k++) a_x[c][8*k +: 8] = rand_sm(maxmag);
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 8; k++) a_wrom[i][8*k +: 8] = rand_sm(maxmag);
        for (int n = 0; n < 4; n++) a_brom[n] = rand_sm(maxmag);
    endtask

    task automatic load_a();
        for (int c = 0; c < A_NC; c++) begin
            a_in_valid = 1'b1;
            a_in_data  = a_x[c];
            check("a_load_ready", 64'(a_in_ready), 64'd1);
            check("a_load_no_result", 64'(a_out_valid), 64'd0);
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        a_in_data  = '0;
    endtask

    // Entered at the first issue cycle of neuron n; returns in the last
    // present cycle. Stray input beats are offered all along.
    task automatic check_issue_a(input int n);
        for (int k = 0; k < A_NC; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = {$urandom, $urandom};
            check("a_waddr", 64'(a_w_addr), 64'(n*A_NC + k));
            check("a_baddr", 64'(a_b_addr), 64'(n));
            check("a_isfirst", 64'(a_pu_isfirst), 64'(k == 1));
            check("a_pu_x", a_pu_x, (k == 0) ? 64'd0 : a_x[k-1]);
            check("a_pu_w", a_pu_w, (k == 0) ? 64'd0 : a_wrom[n*A_NC + k - 1]);
            check("a_in_ready_busy", 64'(a_in_ready), 64'd0);
            check("a_early_valid", 64'(a_out_valid), 64'd0);
            @(negedge clk);
        end
        check("a_waddr_held", 64'(a_w_addr), 64'(n*A_NC + A_NC - 1));
        check("a_last_isfirst", 64'(a_pu_isfirst), 64'd0);
        check("a_last_pu_x", a_pu_x, a_x[A_NC-1]);
        check("a_last_pu_w", a_pu_w, a_wrom[n*A_NC + A_NC - 1]);
        check("a_last_pu_bias", 64'(a_pu_bias), 64'(a_brom[n]));
    endtask

    task automatic run_layer_a(input int dmin, input int dmax);
        bit ok;
        int i, d;
        load_a();
        for (int n = 0; n < A_NN; n++) begin
            check_issue_a(n);
            ok = 1'b0;
            i  = 0;
            while (!ok && i < 60) begin
                @(negedge clk);
                ok = a_out_valid;
                i++;
            end
            check("a_result_timeout", 64'(ok), 64'd1);
            check("a_result_latency", 64'(i), 64'd1);
            check("a_out_data", 64'(a_out_data), 64'(ref_a(n)));
            check("a_out_idx", 64'(a_out_idx), 64'(n));
            d = int'($urandom_range(dmin, dmax));
            for (int j = 0; j < d; j++) begin
                a_out_ready = 1'b0;
                a_in_valid  = 1'b1;
                a_in_data   = {$urandom, $urandom};
                @(negedge clk);
                check("a_hold_valid", 64'(a_out_valid), 64'd1);
                check("a_hold_data", 64'(a_out_data), 64'(ref_a(n)));
                check("a_hold_idx", 64'(a_out_idx), 64'(n));
                check("a_hold_waddr", 64'(a_w_addr), 64'(n*A_NC + A_NC - 1));
                check("a_hold_in_ready", 64'(a_in_ready), 64'd0);
                check("a_hold_isfirst", 64'(a_pu_isfirst), 64'd0);
            end
            a_in_valid  = 1'b0;
            a_out_ready = 1'b1;
            @(negedge clk);
            a_out_ready = 1'b0;
            check("a_valid_drop", 64'(a_out_valid), 64'd0);
            check("a_layer_done", 64'(a_layer_done), 64'(n == A_NN - 1));
        end
        @(negedge clk);
        check("a_done_pulse", 64'(a_layer_done), 64'd0);
        check("a_reload_ready", 64'(a_in_ready), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        b_vecs[0] = '{x_b: 8'h40, w_b: 8'h40, bias: 8'h00, exp_out: 8'h20};
        b_vecs[1] = '{x_b: 8'h40, w_b: 8'hC0, bias: 8'h00, exp_out: 8'h00};
        b_vecs[2] = '{x_b: 8'h40, w_b: 8'h40, bias: 8'h10, exp_out: 8'h30};
        b_vecs[3] = '{x_b: 8'h7F, w_b: 8'h7F, bias: 8'h7F, exp_out: 8'h7F};
        b_vecs[4] = '{x_b: 8'h40, w_b: 8'h40, bias: 8'hA0, exp_out: 8'h00};
        b_vecs[5] = '{x_b: 8'h00, w_b: 8'h55, bias: 8'h05, exp_out: 8'h05};
        b_vecs[6] = '{x_b: 8'hC0, w_b: 8'hC0, bias: 8'h00, exp_out: 8'h20};
        b_vecs[7] = '{x_b: 8'h20, w_b: 8'h60, bias: 8'h81, exp_out: 8'h17};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        b_wrom[0] = '0; b_wrom[1] = '0; b_brom[0] = '0; b_brom[1] = '0;
        randomize_a(20);

        #1;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_idx", 64'(a_out_idx), 64'd0);
        check("rst_layer_done", 64'(a_layer_done), 64'd0);
        check("rst_isfirst", 64'(a_pu_isfirst), 64'd0);
        check("rst_pu_x", a_pu_x, 64'd0);
        check("rst_pu_w", a_pu_w, 64'd0);
        check("rst_pu_bias", 64'(a_pu_bias), 64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready_a", 64'(a_in_ready), 64'd1);
        check("rst_in_ready_b", 64'(b_in_ready), 64'd1);

        // Single-chunk arithmetic cases.
        for (int v = 0; v < 8; v++) run_vec_b(v, b_vecs[v]);

        // Exactly five cycles of back-pressure on every result.
        run_layer_a(5, 5);

        // Reset in the middle of COMPUTE.
        randomize_a(20);
        load_a();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midc_rst_valid", 64'(a_out_valid), 64'd0);
        check("midc_rst_isfirst", 64'(a_pu_isfirst), 64'd0);
        check("midc_rst_pu_x", a_pu_x, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midc_in_ready", 64'(a_in_ready), 64'd1);
        check("midc_no_result", 64'(a_out_valid), 64'd0);
        randomize_a(20);
        run_layer_a(0, 2);

        // Reset while a result is waiting: it must vanish.
        load_a();
        repeat (A_NC + 1) @(negedge clk);
        check("mide_pending", 64'(a_out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mide_rst_valid", 64'(a_out_valid), 64'd0);
        check("mide_rst_data", 64'(a_out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        randomize_a(20);
        run_layer_a(0, 3);

        // Randomised layers, including saturating magnitudes.
        for (int l = 0; l < 12; l++) begin
            randomize_a((l % 4 == 3) ? 127 : 20);
            run_layer_a(0, 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pu_sequencer.md
Name: pu_sequencer

Overview:
- Upstream controller for the 8-lane processing unit (PU); owns one layer's input vector and drives the PU chunk by chunk, one neuron at a time.
- Buffers an input vector of N_CHUNKS 64-bit chunks, each chunk being 8 sign-magnitude bytes.
- Fetches per-neuron weights and bias from synchronous ROMs.
- Drives the PU's x/w/bias/isfirst for every chunk, captures the PU's 8-bit activated output after the last chunk, and emits one result per neuron on a valid/ready stream.

Parameters:
- N_CHUNKS, 4: 64-bit chunks per input vector; vector length is 8*N_CHUNKS bytes; must be ≥1.
- N_NEURONS, 8: neurons per layer.
- CW, clog2(N_CHUNKS) (min 1): chunk index width.
- NW, clog2(N_NEURONS) (min 1): neuron index width.
- AW, clog2(N_NEURONS*N_CHUNKS) (min 1): weight ROM address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input chunk valid.
- in_ready  out  1  sequencer accepts an input chunk.
- in_data  in  64  input chunk; byte k is lane k.
- w_addr  out  AW  weight ROM address.
- w_data  in  64  weight chunk; valid one cycle after w_addr.
- b_addr  out  NW  bias ROM address.
- b_data  in  8  bias; valid one cycle after b_addr.
- pu_x  out  64  to PU x.
- pu_w  out  64  to PU w.
- pu_bias  out  8  to PU bias.
- pu_isfirst  out  1  to PU isfirst.
- pu_out  in  8  PU activated output; combinational in the cycle it is presented.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8  captured neuron result.
- out_idx  out  NW  neuron index of out_data.
- layer_done  out  1  one-cycle pulse after the last neuron's result is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to LOAD; all counters and pipeline regs are cleared.
  - Outputs: in_ready=1 once reset is released; out_valid=0, out_data=0, out_idx=0, layer_done=0, pu_isfirst=0, pu_x=0, pu_w=0, pu_bias=0.
  - Input buffer contents are not cleared.
  - Reset mid-operation abandons the layer; no partial result is emitted.
- LOAD state:
  - in_ready=1.
  - Each in_valid&in_ready beat writes xbuf[ld_cnt] and increments ld_cnt.
  - The beat with ld_cnt=N_CHUNKS-1 moves to COMPUTE with neuron n=0, chunk c=0.
- COMPUTE state (issue stage):
  - in_ready=0.
  - Each cycle, issue w_addr=n*N_CHUNKS+c and b_addr=n (combinational from the counters).
  - Register p_valid=1, p_chunk=c, p_first=(c==0), p_last=(c==N_CHUNKS-1), then increment c.
  - After issuing c=N_CHUNKS-1, issue stops.
- COMPUTE state (present stage, next cycle):
  - When p_valid=1: pu_x=xbuf[p_chunk], pu_w=w_data, pu_bias=b_data, pu_isfirst=p_first.
  - When p_valid=0: pu_x, pu_w and pu_bias are 0 and pu_isfirst=0.
  - On the edge ending the p_last present cycle: out_data<=pu_out, out_idx<=n, out_valid<=1, FSM goes to EMIT.
  - Per-neuron compute latency is N_CHUNKS+1 cycles from the first issue to capture.
- EMIT state:
  - out_valid holds and out_data/out_idx stay stable until out_ready is seen.
  - On out_valid&out_ready: out_valid<=0.
    - If n<N_NEURONS-1: n++, c=0, back to COMPUTE.
    - Otherwise: layer_done=1 for one cycle, FSM goes to LOAD, ld_cnt=0.
  - out_ready=1 in the capture cycle has no effect; the result is always valid for at least one cycle.
- Boundaries:
  - N_CHUNKS=1: every present cycle has both isfirst and p_last set.
  - Counters never wrap past N_CHUNKS-1 or N_NEURONS-1.
  - in_valid outside LOAD is ignored (in_ready=0).
  - Back-pressure from out_ready never corrupts the PU accumulator: the next neuron always restarts with isfirst.

Test Plan:
- Reset sanity: assert rst_n=0 mid-COMPUTE -> immediately out_valid=0, pu_isfirst=0, in_ready=1 once rst_n=1; no stale result appears after reload.
- N_CHUNKS=1, N_NEURONS=1, PU model attached: x lane0=0x40, w lane0=0x40, other lanes 0, bias 0 -> out_data=0x20, out_idx=0, then layer_done pulse.
- N_CHUNKS=2: both chunks x lane0=0x40, w lane0=0x40 -> pu_isfirst pattern 1,0 -> out_data=0x40.
- Negative weight: w lane0=0xC0 -> ReLU output, out_data=0x00.
- Addressing, N_CHUNKS=4, N_NEURONS=3: w_addr sequence 0..3, 4..7, 8..11; b_addr constant per neuron; out_idx 0,1,2 in order.
- Back-pressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stay stable, no new w_addr issued; in_valid during COMPUTE/EMIT is not accepted.
